// File: rtl/multicycle_datapath_pkg.sv
// Shared encodings for the 16-bit multi-cycle datapath: ALU B-source selects, ALU function codes,
// opcodes and instruction field positions.
package multicycle_datapath_pkg;

  typedef enum logic [1:0] {
    SrcBReg  = 2'b00,
    SrcBOne  = 2'b01,
    SrcBImm  = 2'b10,
    SrcBZero = 2'b11
  } srcb_e;

  localparam logic [3:0] FN_ADD = 4'b0000;
  localparam logic [3:0] FN_SUB = 4'b0001;
  localparam logic [3:0] FN_AND = 4'b0010;
  localparam logic [3:0] FN_OR  = 4'b0011;
  localparam logic [3:0] FN_XOR = 4'b0100;
  localparam logic [3:0] FN_SLT = 4'b0101;
  localparam logic [3:0] FN_SHL = 4'b0110;
  localparam logic [3:0] FN_SHR = 4'b0111;

  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_LW   = 3'b011;
  localparam logic [2:0] OP_SW   = 3'b100;
  localparam logic [2:0] OP_BEQ  = 3'b101;
  localparam logic [2:0] OP_NOP  = 3'b110;

  localparam int OP_HI = 15;
  localparam int OP_LO = 13;
  localparam int RD_HI = 12;
  localparam int RD_LO = 10;
  localparam int RS_HI = 9;
  localparam int RS_LO = 7;
  localparam int RT_HI = 6;
  localparam int RT_LO = 4;
  localparam int FN_HI = 3;
  localparam int FN_LO = 0;

  function automatic logic [15:0] sext7(input logic [6:0] v);
    return {{9{v[6]}}, v};
  endfunction

endpackage

// File: rtl/multicycle_datapath_reg_file.sv
// Register file: two asynchronous read ports, one synchronous write port; r0 is hardwired to zero.
module multicycle_datapath_reg_file #(
  parameter int unsigned NREGS = 8,
  parameter int unsigned DW    = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_we,
  input  logic [$clog2(NREGS)-1:0] i_waddr,
  input  logic [DW-1:0]            i_wdata,
  input  logic [$clog2(NREGS)-1:0] i_raddr_a,
  input  logic [$clog2(NREGS)-1:0] i_raddr_b,
  output logic [DW-1:0]            o_rdata_a,
  output logic [DW-1:0]            o_rdata_b
);

  logic [DW-1:0] r_regs [NREGS];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_regs <= '{default: '0};
    end else if (i_we && (i_waddr != '0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = (i_raddr_a == '0) ? '0 : r_regs[i_raddr_a];
  assign o_rdata_b = (i_raddr_b == '0) ? '0 : r_regs[i_raddr_b];

endmodule

// File: rtl/multicycle_datapath.sv
// Datapath half of the multi-cycle CPU: PC/IR/MDR/A/B/ALUOut, register file and ALU, steered
// entirely by the control FSM's per-state strobes.
module multicycle_datapath
  import multicycle_datapath_pkg::*;
#(
  parameter int unsigned   DW       = 16,
  parameter int unsigned   NREGS    = 8,
  parameter logic [DW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          IorD,
  input  logic          MemWrite,
  input  logic          IRWrite,
  input  logic          MemtoReg,
  input  logic          Immsel,
  input  logic          RegWrite,
  input  logic          ALUSrcA,
  input  logic [1:0]    ALUsrcB,
  input  logic          PCsrc,
  input  logic          Branch,
  input  logic          PCWrite,
  input  logic          ALUctrl,
  output logic [2:0]    opcode,
  output logic [3:0]    func,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] pc_dbg
);

  logic [DW-1:0] r_pc, r_ir, r_mdr, r_a, r_b, r_aluout;
  logic [DW-1:0] w_rd_a, w_rd_b, w_wdata, w_imm, w_src_a, w_src_b, w_alu, w_pc_next;
  logic [6:0]    w_imm7;
  logic [3:0]    w_fn;
  logic          w_lt, w_zero;

  multicycle_datapath_reg_file #(
    .NREGS(NREGS),
    .DW   (DW)
  ) u_reg_file (
    .i_clk    (clk),
    .i_rst    (reset),
    .i_we     (RegWrite),
    .i_waddr  (r_ir[RD_HI:RD_LO]),
    .i_wdata  (w_wdata),
    .i_raddr_a(r_ir[RS_HI:RS_LO]),
    .i_raddr_b(r_ir[RT_HI:RT_LO]),
    .o_rdata_a(w_rd_a),
    .o_rdata_b(w_rd_b)
  );

  assign w_wdata = MemtoReg ? r_mdr : r_aluout;

  // Store/branch offsets are split around the rs/rt fields.
  assign w_imm7 = Immsel ? {r_ir[RD_HI:RD_LO], r_ir[FN_HI:FN_LO]} : r_ir[6:0];
  assign w_imm  = sext7(w_imm7);

  assign w_src_a = ALUSrcA ? r_a : r_pc;

  always_comb begin
    w_src_b = r_b;
    unique case (srcb_e'(ALUsrcB))
      SrcBReg:  w_src_b = r_b;
      SrcBOne:  w_src_b = DW'(1);
      SrcBImm:  w_src_b = w_imm;
      SrcBZero: w_src_b = '0;
    endcase
  end

  assign w_lt = $signed(w_src_a) < $signed(w_src_b);
  assign w_fn = ALUctrl ? FN_ADD : (Branch ? FN_SUB : r_ir[FN_HI:FN_LO]);

  always_comb begin
    w_alu = '0;
    case (w_fn)
      FN_ADD:  w_alu = w_src_a + w_src_b;
      FN_SUB:  w_alu = w_src_a - w_src_b;
      FN_AND:  w_alu = w_src_a & w_src_b;
      FN_OR:   w_alu = w_src_a | w_src_b;
      FN_XOR:  w_alu = w_src_a ^ w_src_b;
      FN_SLT:  w_alu = {{(DW-1){1'b0}}, w_lt};
      FN_SHL:  w_alu = w_src_a << w_src_b[3:0];
      FN_SHR:  w_alu = w_src_a >> w_src_b[3:0];
      default: w_alu = '0;
    endcase
  end

  assign w_zero    = (w_alu == '0);
  assign w_pc_next = PCsrc ? r_aluout : w_alu;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_mdr    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_aluout <= '0;
    end else begin
      r_mdr    <= mem_rdata;
      r_a      <= w_rd_a;
      r_b      <= w_rd_b;
      r_aluout <= w_alu;
      if (IRWrite) r_ir <= mem_rdata;
      if (PCWrite || (Branch && w_zero)) r_pc <= w_pc_next;
    end
  end

  assign opcode    = r_ir[OP_HI:OP_LO];
  assign func      = r_ir[FN_HI:FN_LO];
  assign mem_addr  = IorD ? r_aluout : r_pc;
  assign mem_wdata = r_b;
  assign mem_we    = MemWrite;
  assign pc_dbg    = r_pc;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath: tasks play controller sequences, a scoreboard queue
// holds expected outputs and a negedge monitor compares them against the DUT ports.
module tb_multicycle_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic        IorD, MemWrite, IRWrite, MemtoReg, Immsel, RegWrite, ALUSrcA;
  logic        PCsrc, Branch, PCWrite, ALUctrl;
  logic [1:0]  ALUsrcB;
  logic [2:0]  opcode;
  logic [3:0]  func;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, pc_dbg;
  logic        mem_we;
  logic        ovr;
  logic [15:0] ovr_data;
  logic [15:0] mem [0:65535];

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int          sel;
    logic [15:0] val;
    string       name;
  } exp_t;
  exp_t sb[$];

  localparam int S_PC = 0, S_ADDR = 1, S_WDATA = 2, S_WE = 3, S_OP = 4, S_FN = 5;

  multicycle_datapath dut (
    .clk      (clk),
    .reset    (reset),
    .IorD     (IorD),
    .MemWrite (MemWrite),
    .IRWrite  (IRWrite),
    .MemtoReg (MemtoReg),
    .Immsel   (Immsel),
    .RegWrite (RegWrite),
    .ALUSrcA  (ALUSrcA),
    .ALUsrcB  (ALUsrcB),
    .PCsrc    (PCsrc),
    .Branch   (Branch),
    .PCWrite  (PCWrite),
    .ALUctrl  (ALUctrl),
    .opcode   (opcode),
    .func     (func),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata),
    .pc_dbg   (pc_dbg)
  );

  always #5 clk = ~clk;

  // ovr lets the bench feed IR/MDR directly without placing words in memory.
  assign mem_rdata = ovr ? ovr_data : mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  function automatic logic [15:0] observe(input int sel);
    case (sel)
      S_PC:    return pc_dbg;
      S_ADDR:  return mem_addr;
      S_WDATA: return mem_wdata;
      S_WE:    return {15'd0, mem_we};
      S_OP:    return {13'd0, opcode};
      S_FN:    return {12'd0, func};
      default: return 16'hxxxx;
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t        e;
      logic [15:0] got;
      e   = sb.pop_front();
      got = observe(e.sel);
      n_checks++;
      if (got !== e.val) begin
        n_errors++;
        $display("FAIL %s: got %h expected %h", e.name, got, e.val);
      end
    end
  end

  task automatic idle();
    IorD = 0; MemWrite = 0; IRWrite = 0; MemtoReg = 0; Immsel = 0; RegWrite = 0;
    ALUSrcA = 0; ALUsrcB = 2'b00; PCsrc = 0; Branch = 0; PCWrite = 0; ALUctrl = 0;
    ovr = 0; ovr_data = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic push_exp(input int sel, input logic [15:0] v, input string name);
    exp_t e;
    e.sel  = sel;
    e.val  = v;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic load_ir(input logic [15:0] w);
    idle();
    ovr = 1; ovr_data = w; IRWrite = 1;
    tick();
    idle();
  endtask

  task automatic set_reg(input logic [2:0] x, input logic [15:0] v);
    load_ir({3'b000, x, 10'd0});
    ovr = 1; ovr_data = v;
    tick();
    idle();
    RegWrite = 1; MemtoReg = 1;
    tick();
    idle();
  endtask

  task automatic read_reg(input logic [2:0] x, input logic [15:0] v, input string name);
    load_ir({6'd0, x, 7'd0});
    tick();
    ALUSrcA = 1; ALUsrcB = 2'b11; ALUctrl = 1;
    tick();
    idle();
    IorD = 1;
    push_exp(S_ADDR, v, name);
    settle();
    idle();
  endtask

  task automatic fetch();
    idle();
    IRWrite = 1; PCWrite = 1; ALUsrcB = 2'b01; ALUctrl = 1;
    tick();
    idle();
  endtask

  task automatic rtype(input logic [2:0] rd, input logic [2:0] rs, input logic [2:0] rt,
                       input logic [3:0] fn, input logic [15:0] res, input string name);
    load_ir({3'b001, rd, rs, rt, fn});
    tick();
    ALUSrcA = 1; ALUsrcB = 2'b00;
    tick();
    idle();
    IorD = 1; RegWrite = 1;
    push_exp(S_ADDR, res, {name, "_aluout"});
    settle();
    tick();
    idle();
    read_reg(rd, (rd == 3'd0) ? 16'h0000 : res, {name, "_rd"});
  endtask

  task automatic beq_run();
    ALUsrcB = 2'b10; Immsel = 1; ALUctrl = 1;
    tick();
    idle();
    ALUSrcA = 1; Branch = 1; PCsrc = 1;
    tick();
    idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    idle();
    reset = 1;
    for (int i = 0; i < 65536; i++) mem[i] = 16'hC000;
    mem[4]     = 16'h2284;
    mem[8]     = 16'hBCFC;
    mem[16'hD] = 16'hBEEF;
    tick();
    tick();
    reset = 0;
    push_exp(S_PC, 16'h0000, "por_pc");
    push_exp(S_OP, 16'h0000, "por_opcode");
    push_exp(S_FN, 16'h0000, "por_func");
    settle();

    // Asynchronous reset landing in the middle of a fetch.
    for (int r = 1; r < 8; r++) set_reg(3'(r), 16'h1110 + 16'(r));
    fetch();
    push_exp(S_OP, 16'h0006, "pre_reset_opcode");
    settle();
    IRWrite = 1; PCWrite = 1; ALUsrcB = 2'b01; ALUctrl = 1;
    @(posedge clk);
    #2;
    reset = 1;
    #1;
    push_exp(S_PC, 16'h0000, "rst_pc");
    push_exp(S_OP, 16'h0000, "rst_opcode");
    push_exp(S_FN, 16'h0000, "rst_func");
    push_exp(S_WE, 16'h0000, "rst_mem_we");
    settle();
    tick();
    idle();
    reset = 0;
    for (int r = 1; r < 8; r++) read_reg(3'(r), 16'h0000, $sformatf("rst_r%0d", r));

    // Fetch sequence up to the instruction at address 4.
    repeat (4) fetch();
    push_exp(S_PC, 16'h0004, "fetch_pc4");
    settle();
    fetch();
    push_exp(S_PC, 16'h0005, "fetch_pc5");
    push_exp(S_OP, 16'h0001, "fetch_opcode");
    push_exp(S_FN, 16'h0004, "fetch_func");
    settle();

    // R-type with r1=7, r2=5.
    set_reg(3'd1, 16'h0007);
    set_reg(3'd2, 16'h0005);
    rtype(3'd3, 3'd1, 3'd2, 4'b0001, 16'h0002, "sub_7_5");
    rtype(3'd4, 3'd1, 3'd2, 4'b0101, 16'h0000, "slt_7_5");
    rtype(3'd5, 3'd2, 3'd1, 4'b0101, 16'h0001, "slt_5_7");
    rtype(3'd6, 3'd2, 3'd1, 4'b0001, 16'hFFFE, "sub_5_7");
    rtype(3'd7, 3'd6, 3'd2, 4'b0111, 16'h07FF, "shr_logical");
    rtype(3'd3, 3'd6, 3'd2, 4'b0101, 16'h0001, "slt_signed_neg");
    rtype(3'd3, 3'd1, 3'd2, 4'b0010, 16'h0005, "and");
    rtype(3'd4, 3'd1, 3'd2, 4'b0011, 16'h0007, "or");
    rtype(3'd5, 3'd1, 3'd2, 4'b0100, 16'h0002, "xor");
    rtype(3'd6, 3'd1, 3'd2, 4'b0110, 16'h00E0, "shl");
    rtype(3'd7, 3'd1, 3'd2, 4'b1111, 16'h0000, "func_undef");
    rtype(3'd0, 3'd1, 3'd2, 4'b0000, 16'h000C, "add_to_r0");
    set_reg(3'd0, 16'hAAAA);
    read_reg(3'd0, 16'h0000, "r0_write_dropped");

    // ADDI/LW address calc with imm=-3, then load from 0x000D into r4.
    set_reg(3'd1, 16'h0010);
    load_ir({3'b011, 3'd4, 3'd1, 7'h7D});
    tick();
    ALUSrcA = 1; ALUsrcB = 2'b10; ALUctrl = 1;
    tick();
    idle();
    IorD = 1;
    push_exp(S_ADDR, 16'h000D, "lw_addr");
    settle();
    tick();
    idle();
    RegWrite = 1; MemtoReg = 1;
    tick();
    idle();
    read_reg(3'd4, 16'hBEEF, "lw_rt");

    // SW with split offset +2.
    set_reg(3'd5, 16'h0020);
    set_reg(3'd6, 16'h1234);
    load_ir({3'b100, 3'b000, 3'd5, 3'd6, 4'b0010});
    tick();
    ALUSrcA = 1; ALUsrcB = 2'b10; Immsel = 1; ALUctrl = 1;
    tick();
    idle();
    IorD = 1; MemWrite = 1;
    push_exp(S_ADDR, 16'h0022, "sw_addr");
    push_exp(S_WDATA, 16'h1234, "sw_wdata");
    push_exp(S_WE, 16'h0001, "sw_we");
    settle();
    tick();
    idle();
    push_exp(S_WE, 16'h0000, "sw_we_drop");
    settle();

    // BEQ at address 8, offset -4: taken when A==B, not taken otherwise.
    set_reg(3'd1, 16'h0007);
    set_reg(3'd7, 16'h0007);
    repeat (4) fetch();
    push_exp(S_PC, 16'h0009, "beq_fetch_pc");
    push_exp(S_OP, 16'h0005, "beq_opcode");
    settle();
    beq_run();
    push_exp(S_PC, 16'h0005, "beq_taken");
    settle();
    set_reg(3'd7, 16'h0008);
    repeat (4) fetch();
    beq_run();
    push_exp(S_PC, 16'h0009, "beq_not_taken");
    settle();

    // PC wrap: ALUOut = 9 - 10 = 0xFFFF, then fetch increments to 0.
    load_ir({3'b010, 3'd0, 3'd0, 7'h76});
    ALUsrcB = 2'b10; ALUctrl = 1;
    tick();
    idle();
    PCWrite = 1; PCsrc = 1;
    tick();
    idle();
    push_exp(S_PC, 16'hFFFF, "pc_from_aluout");
    settle();
    fetch();
    push_exp(S_PC, 16'h0000, "pc_wrap");
    push_exp(S_OP, 16'h0006, "wrap_opcode");
    settle();

    settle();
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
